dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder serving the memory-stage requests of the pipelined ARM datapath. It accepts a word or byte load/store (address from the M-stage ALU result, store data from the M-stage write-data register), models a configurable number of wait states, and returns load data together with a stall signal that the hazard unit ORs into its fetch/decode/execute stall terms. It is the memory-side end of the datapath's data port and replaces the ideal zero-latency data RAM.

## Interface
- `ADDR_W`, 6: word-address bits; RAM depth is 2^ADDR_W words.
- `WAIT_CYC`, 2: wait states per access, 0..15.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `MemReq_M` in 1: M stage holds a load or store.
- `MemWrite_M` in 1: 1 = store, 0 = load; qualified by `MemReq_M`.
- `ByteM` in 1: byte access (LDRB/STRB); 0 = word.
- `ALUO_M` in 32: byte address.
- `WriteDataM` in 32: store data; for a byte store, bits [7:0] are used.
- `DataR_M` out 32: load data; a byte load returns the zero-extended byte.
- `Mem_stall` out 1: hold the pipeline; the M-stage request must stay stable while it is high.
- `Mem_fault` out 1: single-cycle pulse on a faulting access.

## Operation
- States: IDLE, WAIT, DONE. A 4-bit down-counter `cnt` times the wait states.
- IDLE, `MemReq_M`=1, `WAIT_CYC`>0:
  - Latch address, data, write and byte controls.
  - `cnt` <= `WAIT_CYC`-1; next state is WAIT.
- WAIT:
  - If `cnt`==0: perform the access, register the read data into `DataR_M`, go to DONE.
  - Otherwise decrement `cnt`.
- DONE: lasts one cycle, then IDLE. `MemReq_M` is ignored in DONE because it is the request that is retiring.
- `Mem_stall` = (IDLE & `MemReq_M` & `WAIT_CYC`!=0) | WAIT. It is low in DONE and low during reset.
- `WAIT_CYC`==0:
  - The FSM stays in IDLE.
  - Load data is driven combinationally from the RAM.
  - A store commits on the same rising edge.
  - `Mem_stall` stays 0.
- Store commit: only on the WAIT->DONE edge, or on the IDLE edge when `WAIT_CYC`==0. Nothing is written earlier.
- Byte lanes are little-endian. Lane = addr[1:0]:
  - Byte store writes only that lane.
  - Byte load returns {24'b0, lane}.
- Fault condition: (word access & addr[1:0]!=0) | (addr[31:ADDR_W+2]!=0). On a fault:
  - The store is suppressed.
  - `DataR_M` = 0.
  - `Mem_fault` = 1 for the DONE cycle (or the request cycle when `WAIT_CYC`==0).
- `DataR_M` holds its last value in IDLE when `WAIT_CYC`>0.
- With `MemReq_M`=0, all other request inputs are don't-care and there is no RAM side effect.

## Timing
- Reset values:
  - State IDLE, `cnt` 0.
  - `DataR_M` 0, `Mem_stall` 0, `Mem_fault` 0.
  - RAM contents are not reset.
- Reset mid-access: the access is abandoned. A store that has not reached its commit edge is never written.
- Latency, `WAIT_CYC`=N>0:
  - `Mem_stall` is high for N+1 cycles (request cycle plus N WAIT cycles).
  - Data is valid in the following DONE cycle.
  - The request is held for N+2 cycles in total.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE. There is one bubble cycle with `Mem_stall`=0 only if `MemReq_M`=0 in that cycle.
- A load immediately after a store to the same word returns the stored data, because the store has committed by the time of the later access.

## Structure
- Package `mem_pkg` holds:
  - `mem_state_t` enum {IDLE, WAIT, DONE}.
  - `WAIT_W`=4.
  - A fault-check function.
  - Default parameter constants.
- Sub-module `dmem_ram`: 2^ADDR_W x 32 storage with four byte-write enables, an asynchronous read port and a synchronous write port. `dmem_responder` contains the FSM, counter, lane select and fault logic.

## Test plan
- `WAIT_CYC`=2, word store 0xDEADBEEF @0x10, then word load @0x10 -> `Mem_stall` high 3 cycles per access; `DataR_M`=0xDEADBEEF in the load's DONE cycle.
- Byte store 0xA5 @0x13 over word 0x11223344 @0x10, then word load @0x10 -> 0xA5223344. Byte load @0x12 -> 0x00000022.
- Word load @0x12 (misaligned) -> `Mem_fault` pulses 1 cycle in DONE, `DataR_M`=0. Store @0x400 with `ADDR_W`=6 -> fault, RAM unchanged.
- `reset_n` low during WAIT of a store 0x5 @0x20 -> state IDLE, `Mem_stall` 0 immediately; later load @0x20 returns the old value.
- `WAIT_CYC`=0, alternating store/load every cycle -> `Mem_stall` never high; a load one cycle after a store to the same address returns the new data.
- `MemReq_M` held high continuously with `WAIT_CYC`=1 -> stall pattern 1,1,0 repeating; each access is counted exactly once (a store counter in the bench matches the request count).

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared types, widths and helpers for the data-memory responder.
//   mem_state_t    : responder FSM states
//   WAIT_W         : width of the wait-state down-counter
//   DEF_ADDR_W     : default word-address width
//   DEF_WAIT_CYC   : default number of wait states
//   mem_fault_chk(): flags misaligned word accesses and out-of-range addresses
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int unsigned WAIT_W       = 4;
  localparam int unsigned DEF_ADDR_W   = 6;
  localparam int unsigned DEF_WAIT_CYC = 2;

  // A byte address faults when a word access is not word aligned, or when any
  // bit above the implemented RAM range is set.
  function automatic logic mem_fault_chk(input logic [31:0] addr, input logic is_byte,
                                         input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (!is_byte && (addr[1:0] != 2'b00)) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: 2^ADDR_W x 32 data storage.
//   clk   : write clock
//   we    : write enable
//   be    : per-byte write enables, bit i covers wdata[8i+7:8i]
//   addr  : word address, shared by read and write
//   wdata : write data
//   rdata : asynchronous read data
module dmem_ram #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-stage data port with configurable wait states.
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   MemReq_M     : M stage holds a load or store
//   MemWrite_M   : 1 = store, 0 = load
//   ByteM        : byte access when 1, word access when 0
//   ALUO_M       : byte address
//   WriteDataM   : store data ([7:0] for byte stores)
//   DataR_M      : load data, zero-extended for byte loads, 0 on a fault
//   Mem_stall    : pipeline hold while the access is in flight
//   Mem_fault    : one-cycle pulse for a faulting access
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        MemReq_M,
  input  logic        MemWrite_M,
  input  logic        ByteM,
  input  logic [31:0] ALUO_M,
  input  logic [31:0] WriteDataM,
  output logic [31:0] DataR_M,
  output logic        Mem_stall,
  output logic        Mem_fault
);

  localparam bit ZERO_WAIT = (WAIT_CYC == 0);

  mem_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       addr_q, wdata_q;
  logic              write_q, byte_q;
  logic [31:0]       data_q;
  logic              fault_q;

  // With no wait states the live request drives the RAM directly; otherwise
  // the request latched in IDLE does.
  logic [31:0] acc_addr, acc_wdata;
  logic        acc_byte, acc_fault;
  logic [1:0]  lane;
  logic [31:0] rword, load_data, ram_wdata;
  logic [3:0]  ram_be;
  logic        commit, ram_we;

  assign acc_addr  = ZERO_WAIT ? ALUO_M     : addr_q;
  assign acc_wdata = ZERO_WAIT ? WriteDataM : wdata_q;
  assign acc_byte  = ZERO_WAIT ? ByteM      : byte_q;
  assign acc_fault = mem_fault_chk(acc_addr, acc_byte, ADDR_W);
  assign lane      = acc_addr[1:0];

  assign load_data = acc_fault ? 32'd0 :
                     acc_byte  ? {24'd0, rword[{lane, 3'b000} +: 8]} : rword;

  assign ram_be    = acc_byte ? (4'b0001 << lane) : 4'hF;
  assign ram_wdata = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;

  // Stores commit only on the edge that completes the access.
  assign commit = ZERO_WAIT ? (MemReq_M & MemWrite_M)
                            : ((state_q == WAIT) && (cnt_q == '0) && write_q);
  assign ram_we = commit & ~acc_fault & reset_n;

  dmem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (acc_addr[ADDR_W+1:2]),
    .wdata (ram_wdata),
    .rdata (rword)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (MemReq_M && !ZERO_WAIT) begin
          state_d = WAIT;
          cnt_d   = WAIT_W'(WAIT_CYC - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
      data_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && MemReq_M) begin
        addr_q  <= ALUO_M;
        wdata_q <= WriteDataM;
        write_q <= MemWrite_M;
        byte_q  <= ByteM;
      end
      if (!ZERO_WAIT && state_q == WAIT && cnt_q == '0) begin
        data_q  <= load_data;
        fault_q <= acc_fault;
      end
    end
  end

  // Outputs are gated by reset_n so they read 0 while reset is asserted even
  // if the pipeline keeps presenting a request.
  assign Mem_stall = reset_n & (((state_q == IDLE) & MemReq_M & !ZERO_WAIT) |
                                (state_q == WAIT));
  assign Mem_fault = reset_n & (ZERO_WAIT ? (MemReq_M & acc_fault)
                                          : ((state_q == DONE) & fault_q));
  assign DataR_M   = ZERO_WAIT ? (reset_n ? load_data : 32'd0) : data_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req2, req0, req1;
  logic        we, by;
  logic [31:0] addr, wd;
  logic [31:0] data2, data0, data1;
  logic        st2, st0, st1;
  logic        f2, f0, f1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] rd;
  int          nst, nflt, ndone;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(6), .WAIT_CYC(2)) u_w2 (
    .clk(clk), .reset_n(reset_n), .MemReq_M(req2), .MemWrite_M(we), .ByteM(by),
    .ALUO_M(addr), .WriteDataM(wd), .DataR_M(data2), .Mem_stall(st2), .Mem_fault(f2)
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYC(0)) u_w0 (
    .clk(clk), .reset_n(reset_n), .MemReq_M(req0), .MemWrite_M(we), .ByteM(by),
    .ALUO_M(addr), .WriteDataM(wd), .DataR_M(data0), .Mem_stall(st0), .Mem_fault(f0)
  );

  dmem_responder #(.ADDR_W(6), .WAIT_CYC(1)) u_w1 (
    .clk(clk), .reset_n(reset_n), .MemReq_M(req1), .MemWrite_M(we), .ByteM(by),
    .ALUO_M(addr), .WriteDataM(wd), .DataR_M(data1), .Mem_stall(st1), .Mem_fault(f1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One access on the 2-wait-state responder; entered and left at posedge+1.
  task automatic acc2(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output int nstall, output int nfault);
    bit done;
    req2 = 1'b1; we = w; by = b; addr = a; wd = d;
    nstall = 0; nfault = 0; rdata = 'x; done = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (f2) nfault++;
      if (st2) nstall++;
      else begin
        rdata = data2;
        done  = 1'b1;
      end
    end
    @(posedge clk); #1;
    req2 = 1'b0;
  endtask

  logic [31:0] za [4] = '{32'h08, 32'h08, 32'h0C, 32'h30};
  logic [31:0] zd [4] = '{32'h0BAD_F00D, 32'h1234_5678, 32'hA1B2_C3D4, 32'h5566_7788};

  initial begin
    reset_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we = 1'b0; by = 1'b0; addr = '0; wd = '0;
    req2 = 1'b1;  // request presented while in reset must not stall
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(st2), 32'd0);
    check("rst_data", data2, 32'd0);
    check("rst_fault", 32'(f2), 32'd0);
    check("rst_data0", data0, 32'd0);
    req2 = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Word store then load, 2 wait states
    acc2(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, nst, nflt);
    check("st_stall_cycles", 32'(nst), 32'd3);
    check("st_fault", 32'(nflt), 32'd0);
    acc2(1'b0, 1'b0, 32'h10, 32'h0, rd, nst, nflt);
    check("ld_stall_cycles", 32'(nst), 32'd3);
    check("ld_data", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("idle_hold_data", data2, 32'hDEAD_BEEF);
    check("idle_stall", 32'(st2), 32'd0);
    @(posedge clk); #1;

    // Byte lanes
    acc2(1'b1, 1'b0, 32'h10, 32'h1122_3344, rd, nst, nflt);
    acc2(1'b1, 1'b1, 32'h13, 32'h0000_00A5, rd, nst, nflt);
    check("bst_fault", 32'(nflt), 32'd0);
    acc2(1'b0, 1'b0, 32'h10, 32'h0, rd, nst, nflt);
    check("bst_merge", rd, 32'hA522_3344);
    acc2(1'b0, 1'b1, 32'h12, 32'h0, rd, nst, nflt);
    check("bld_lane2", rd, 32'h0000_0022);

    // Faults
    acc2(1'b0, 1'b0, 32'h12, 32'h0, rd, nst, nflt);
    check("misalign_fault_pulses", 32'(nflt), 32'd1);
    check("misalign_data", rd, 32'd0);
    @(negedge clk);
    check("fault_after_done", 32'(f2), 32'd0);
    @(posedge clk); #1;
    acc2(1'b1, 1'b0, 32'h0, 32'hCAFE_0000, rd, nst, nflt);
    acc2(1'b1, 1'b0, 32'h400, 32'hFFFF_FFFF, rd, nst, nflt);
    check("range_fault_pulses", 32'(nflt), 32'd1);
    acc2(1'b0, 1'b0, 32'h0, 32'h0, rd, nst, nflt);
    check("range_store_suppressed", rd, 32'hCAFE_0000);

    // Reset in the middle of a store
    acc2(1'b1, 1'b0, 32'h20, 32'h0000_1234, rd, nst, nflt);
    req2 = 1'b1; we = 1'b1; by = 1'b0; addr = 32'h20; wd = 32'h5;
    @(posedge clk);
    @(negedge clk);
    check("wait_stall", 32'(st2), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_mid_stall", 32'(st2), 32'd0);
    check("rst_mid_data", data2, 32'd0);
    req2 = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    acc2(1'b0, 1'b0, 32'h20, 32'h0, rd, nst, nflt);
    check("rst_store_dropped", rd, 32'h0000_1234);

    // Zero wait states: alternating store/load every cycle
    req0 = 1'b1; by = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; addr = za[i]; wd = zd[i];
      @(negedge clk);
      check("zw_st_stall", 32'(st0), 32'd0);
      check("zw_st_fault", 32'(f0), 32'd0);
      @(posedge clk); #1;
      we = 1'b0; wd = 32'h0;
      @(negedge clk);
      check("zw_ld_stall", 32'(st0), 32'd0);
      check("zw_ld_data", data0, zd[i]);
      @(posedge clk); #1;
    end
    we = 1'b0; addr = 32'h5;
    @(negedge clk);
    check("zw_fault", 32'(f0), 32'd1);
    check("zw_fault_data", data0, 32'd0);
    @(posedge clk); #1;
    we = 1'b1; by = 1'b1; addr = 32'h31; wd = 32'h7E;
    @(posedge clk); #1;
    we = 1'b0; by = 1'b0; addr = 32'h30;
    @(negedge clk);
    check("zw_byte_merge", data0, 32'h5566_7E88);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("zw_idle_fault", 32'(f0), 32'd0);
    @(posedge clk); #1;

    // One wait state, request held high continuously
    req1 = 1'b1; by = 1'b0; we = 1'b1; ndone = 0;
    for (int i = 0; i < 6; i++) begin
      addr = 32'h80 + 32'(4 * i); wd = 32'h100 + 32'(i);
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        check("w1_st_stall", 32'(st1), (j == 2) ? 32'd0 : 32'd1);
        if (!st1) ndone++;
      end
      @(posedge clk); #1;
    end
    check("w1_access_count", 32'(ndone), 32'd6);
    we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      addr = 32'h80 + 32'(4 * i);
      repeat (3) @(negedge clk);
      check("w1_ld_data", data1, 32'h100 + 32'(i));
      @(posedge clk); #1;
    end
    req1 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
